// File: rtl/sprite_engine.sv
`timescale 1ns/1ps
// Sprite engine: holds the 1-bit sprite bitmap and X/Y position, and renders the sprite
// against the raster counters through a 2-stage pipeline.
module sprite_engine #(
    parameter int SPRITE_W   = 8,
    parameter int SPRITE_H   = 8,
    parameter int POS_W      = 6,
    parameter int POS_SHIFT  = 3,
    parameter int SCALE_LOG2 = 2,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sprite_shift,
    input  logic             shift_x,
    input  logic             shift_y,
    input  logic             mosi_bit,
    input  logic             mirror_x,
    input  logic             mirror_y,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    input  logic             pixel_en,
    output logic             sprite_data,
    output logic             sprite_on,
    output logic             sprite_pixel
);

    localparam int N     = SPRITE_W * SPRITE_H;
    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int IDX_W = $clog2(N);

    localparam logic [CNT_W:0] WIN_W = (CNT_W+1)'(SPRITE_W << SCALE_LOG2);
    localparam logic [CNT_W:0] WIN_H = (CNT_W+1)'(SPRITE_H << SCALE_LOG2);

    logic [N-1:0]     bitmap;
    logic [POS_W-1:0] pend_x, pend_y, act_x, act_y;

    // Shadowed position: act only changes at frame start, so a move never tears mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitmap <= '0;
            pend_x <= '0;
            pend_y <= '0;
            act_x  <= '0;
            act_y  <= '0;
        end else begin
            if (sprite_shift)
                bitmap <= {bitmap[N-2:0], mosi_bit};
            if (shift_x)
                pend_x <= {pend_x[POS_W-2:0], mosi_bit};
            if (shift_y)
                pend_y <= {pend_y[POS_W-2:0], mosi_bit};
            if (frame_start) begin
                act_x <= pend_x;
                act_y <= pend_y;
            end
        end
    end

    assign sprite_data = bitmap[N-1];

    logic [CNT_W:0]   origin_x, origin_y, rel_x, rel_y;
    logic             in_x, in_y;
    logic [COL_W-1:0] col_raw, col_next;
    logic [ROW_W-1:0] row_raw, row_next;

    // One extra bit keeps rel_x/rel_y signed so a raster left of or above the origin is outside.
    assign origin_x = {{(CNT_W+1-POS_W){1'b0}}, act_x} << POS_SHIFT;
    assign origin_y = {{(CNT_W+1-POS_W){1'b0}}, act_y} << POS_SHIFT;
    assign rel_x    = {1'b0, hcount} - origin_x;
    assign rel_y    = {1'b0, vcount} - origin_y;
    assign in_x     = !rel_x[CNT_W] && (rel_x < WIN_W);
    assign in_y     = !rel_y[CNT_W] && (rel_y < WIN_H);
    assign col_raw  = rel_x[SCALE_LOG2 +: COL_W];
    assign row_raw  = rel_y[SCALE_LOG2 +: ROW_W];
    assign col_next = mirror_x ? COL_W'(SPRITE_W-1) - col_raw : col_raw;
    assign row_next = mirror_y ? ROW_W'(SPRITE_H-1) - row_raw : row_raw;

    logic             s1_in_win;
    logic [COL_W-1:0] s1_col;
    logic [ROW_W-1:0] s1_row;
    logic [IDX_W-1:0] s2_idx;

    assign s2_idx = IDX_W'(s1_row) * IDX_W'(SPRITE_W) + IDX_W'(s1_col);

    // Stage 1 resolves the window and sprite cell; stage 2 looks up the live bitmap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_in_win    <= 1'b0;
            s1_col       <= '0;
            s1_row       <= '0;
            sprite_on    <= 1'b0;
            sprite_pixel <= 1'b0;
        end else begin
            s1_in_win    <= pixel_en && in_x && in_y;
            s1_col       <= col_next;
            s1_row       <= row_next;
            sprite_on    <= s1_in_win;
            sprite_pixel <= s1_in_win & bitmap[IDX_W'(N-1) - s2_idx];
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
`timescale 1ns/1ps
// Directed testbench for sprite_engine: hand-computed probes plus a row sweep
// checked against a small behavioural model of the window and bitmap lookup.
module tb_sprite_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       sprite_shift, shift_x, shift_y, mosi_bit;
    logic       mirror_x, mirror_y, frame_start;
    logic [9:0] hcount, vcount;
    logic       pixel_en;
    logic       sprite_data, sprite_on, sprite_pixel;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_bitmap;
    logic [5:0]  m_pend_x, m_pend_y, m_act_x, m_act_y;

    sprite_engine dut (
        .clk          (clk),
        .reset        (reset),
        .sprite_shift (sprite_shift),
        .shift_x      (shift_x),
        .shift_y      (shift_y),
        .mosi_bit     (mosi_bit),
        .mirror_x     (mirror_x),
        .mirror_y     (mirror_y),
        .frame_start  (frame_start),
        .hcount       (hcount),
        .vcount       (vcount),
        .pixel_en     (pixel_en),
        .sprite_data  (sprite_data),
        .sprite_on    (sprite_on),
        .sprite_pixel (sprite_pixel)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One strobe cycle; the model mirrors the shadow rule (act takes the pre-shift pend).
    task automatic applyStimulus(input bit sb, input bit sx, input bit sy, input bit mosi, input bit fs);
        sprite_shift = sb;
        shift_x      = sx;
        shift_y      = sy;
        mosi_bit     = mosi;
        frame_start  = fs;
        if (fs) begin
            m_act_x = m_pend_x;
            m_act_y = m_pend_y;
        end
        if (sb) m_bitmap = {m_bitmap[62:0], mosi};
        if (sx) m_pend_x = {m_pend_x[4:0], mosi};
        if (sy) m_pend_y = {m_pend_y[4:0], mosi};
        tick();
        sprite_shift = 1'b0;
        shift_x      = 1'b0;
        shift_y      = 1'b0;
        mosi_bit     = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic applyReset;
        reset    = 1'b1;
        m_bitmap = '0;
        m_pend_x = '0;
        m_pend_y = '0;
        m_act_x  = '0;
        m_act_y  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic shiftX(input logic [5:0] v);
        for (int i = 5; i >= 0; i--) applyStimulus(0, 1, 0, v[i], 0);
    endtask

    task automatic shiftY(input logic [5:0] v);
        for (int i = 5; i >= 0; i--) applyStimulus(0, 0, 1, v[i], 0);
    endtask

    function automatic logic [1:0] expOut(input int h, input int v, input bit en);
        int  rx, ry, c, r;
        bit  on;
        rx = h - int'(m_act_x) * 8;
        ry = v - int'(m_act_y) * 8;
        on = en && rx >= 0 && rx < 32 && ry >= 0 && ry < 32;
        if (!on) return 2'b00;
        c = rx / 4;
        r = ry / 4;
        if (mirror_x) c = 7 - c;
        if (mirror_y) r = 7 - r;
        return {1'b1, m_bitmap[63 - (r * 8 + c)]};
    endfunction

    task automatic probeCheck(input string tag, input int h, input int v, input bit en, input logic [1:0] exp);
        hcount   = 10'(h);
        vcount   = 10'(v);
        pixel_en = en;
        tick();
        tick();
        checkOutput(tag, {30'd0, sprite_on, sprite_pixel}, {30'd0, exp});
    endtask

    // Streams one raster row; each sample must equal the model for the input two edges back.
    task automatic runRow(input string tag, input int h0, input int h1, input int v);
        logic [1:0] prev;
        bit         have;
        prev = 2'b00;
        have = 1'b0;
        for (int h = h0; h <= h1; h++) begin
            hcount   = 10'(h);
            vcount   = 10'(v);
            pixel_en = 1'b1;
            tick();
            if (have) checkOutput(tag, {30'd0, sprite_on, sprite_pixel}, {30'd0, prev});
            prev = expOut(h, v, 1'b1);
            have = 1'b1;
        end
        pixel_en = 1'b0;
        tick();
        checkOutput(tag, {30'd0, sprite_on, sprite_pixel}, {30'd0, prev});
    endtask

    initial begin
        reset        = 1'b1;
        sprite_shift = 1'b0;
        shift_x      = 1'b0;
        shift_y      = 1'b0;
        mosi_bit     = 1'b0;
        mirror_x     = 1'b0;
        mirror_y     = 1'b0;
        frame_start  = 1'b0;
        hcount       = '0;
        vcount       = '0;
        pixel_en     = 1'b0;
        applyReset();
        checkOutput("rst_data", {31'd0, sprite_data}, 32'd0);
        checkOutput("rst_out", {30'd0, sprite_on, sprite_pixel}, 32'd0);

        $display("[TB] test 1: bitmap load");
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1, 0, 0, (i == 0 || i == 63), 0);
            if (i == 62) checkOutput("t1_data63", {31'd0, sprite_data}, 32'd0);
        end
        checkOutput("t1_data64", {31'd0, sprite_data}, 32'd1);
        probeCheck("t1_p00", 0, 0, 1, 2'b11);
        probeCheck("t1_p77", 31, 31, 1, 2'b11);
        probeCheck("t1_p01", 4, 0, 1, 2'b10);
        probeCheck("t1_p76", 27, 31, 1, 2'b10);
        runRow("t1_row0", 0, 35, 0);
        runRow("t1_row28", 0, 35, 28);

        $display("[TB] test 2: position");
        shiftX(6'b000101);
        shiftY(6'b000010);
        applyStimulus(0, 0, 0, 0, 1);
        probeCheck("t2_h39", 39, 16, 1, 2'b00);
        probeCheck("t2_h40", 40, 16, 1, 2'b11);
        probeCheck("t2_h71", 71, 16, 1, 2'b10);
        probeCheck("t2_h72", 72, 16, 1, 2'b00);
        probeCheck("t2_p77", 70, 47, 1, 2'b11);
        probeCheck("t2_v48", 40, 48, 1, 2'b00);
        probeCheck("t2_v15", 40, 15, 1, 2'b00);
        runRow("t2_row16", 36, 76, 16);
        runRow("t2_row47", 36, 76, 47);

        $display("[TB] test 3: shadowed position");
        shiftX(6'b001000);
        probeCheck("t3_nomove", 80, 16, 1, 2'b00);
        probeCheck("t3_old", 40, 16, 1, 2'b11);
        applyStimulus(0, 0, 0, 0, 1);
        probeCheck("t3_new", 80, 16, 1, 2'b10);
        probeCheck("t3_oldgone", 40, 16, 1, 2'b00);
        probeCheck("t3_new_p00", 64, 16, 1, 2'b11);
        applyStimulus(0, 1, 0, 1, 1);
        probeCheck("t3_coin_act", 64, 16, 1, 2'b11);
        probeCheck("t3_coin_notnew", 136, 16, 1, 2'b00);
        applyStimulus(0, 0, 0, 0, 1);
        probeCheck("t3_pend17", 136, 16, 1, 2'b11);
        probeCheck("t3_pend17_old", 64, 16, 1, 2'b00);

        $display("[TB] test 4: mirroring");
        shiftX(6'b000101);
        applyStimulus(0, 0, 0, 0, 1);
        mirror_x = 1'b1;
        probeCheck("t4_h68", 68, 16, 1, 2'b11);
        probeCheck("t4_h71", 71, 16, 1, 2'b11);
        probeCheck("t4_h67", 67, 16, 1, 2'b10);
        probeCheck("t4_h40", 40, 16, 1, 2'b10);
        runRow("t4_mx_row16", 36, 76, 16);
        mirror_y = 1'b1;
        probeCheck("t4_xy_h40", 40, 16, 1, 2'b11);
        probeCheck("t4_xy_h68", 68, 16, 1, 2'b10);
        mirror_x = 1'b0;
        probeCheck("t4_y_h68", 68, 16, 1, 2'b11);
        runRow("t4_my_row44", 36, 76, 44);
        mirror_y = 1'b0;

        $display("[TB] test 5: edge of raster");
        shiftX(6'b111111);
        applyStimulus(0, 0, 0, 0, 1);
        probeCheck("t5_h503", 503, 16, 1, 2'b00);
        probeCheck("t5_h504", 504, 16, 1, 2'b11);
        probeCheck("t5_h535", 535, 16, 1, 2'b10);
        probeCheck("t5_h536", 536, 16, 1, 2'b00);
        probeCheck("t5_h0", 0, 16, 1, 2'b00);
        probeCheck("t5_h1023", 1023, 16, 1, 2'b00);
        probeCheck("t5_pen0", 504, 16, 0, 2'b00);
        shiftY(6'b111111);
        applyStimulus(0, 0, 0, 0, 1);
        probeCheck("t5_y504", 504, 504, 1, 2'b11);
        probeCheck("t5_ywrap", 504, 0, 1, 2'b00);
        runRow("t5_row535", 500, 540, 535);

        $display("[TB] test 6: reset mid-load");
        applyReset();
        for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        probeCheck("t6_pre", 84, 28, 1, 2'b11);
        #2;
        reset = 1'b1;
        m_bitmap = '0;
        m_pend_x = '0;
        m_pend_y = '0;
        m_act_x  = '0;
        m_act_y  = '0;
        #1;
        checkOutput("t6_async_out", {30'd0, sprite_on, sprite_pixel}, 32'd0);
        checkOutput("t6_async_data", {31'd0, sprite_data}, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        probeCheck("t6_pos_clear", 84, 28, 1, 2'b00);
        probeCheck("t6_bmp_clear", 28, 28, 1, 2'b10);
        applyStimulus(0, 0, 0, 0, 1);
        probeCheck("t6_pend_clear", 28, 28, 1, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
